// File: rtl/int_logic_pkg.sv
// -----------------------------------------------------------------------------
// int_logic_pkg
// Shared types and limits for the pipelined integer logic/compare unit.
//   logic_op_e  : operation code carried with each operand beat
//   LATENCY_MAX : deepest supported pipeline
// -----------------------------------------------------------------------------
package int_logic_pkg;

    typedef enum logic [2:0] {
        OP_OR    = 3'd0,
        OP_AND   = 3'd1,
        OP_SLT   = 3'd2,
        OP_SLTU  = 3'd3,
        OP_XOR   = 3'd4,
        OP_NOR   = 3'd5,
        OP_PASSA = 3'd6,
        OP_ZERO  = 3'd7
    } logic_op_e;

    localparam int LATENCY_MAX = 4;

endpackage

// File: rtl/int_logic_if.sv
// -----------------------------------------------------------------------------
// int_logic_if
// Operand/result handshake bundle for int_logic_pipe.
//   in_valid/in_ready   : operand beat handshake (a, b, op travel with it)
//   out_valid/out_ready : result handshake (dout travels with it)
//   busy                : some pipeline stage holds a beat
//   out_zero/out_neg    : result flags, present only with INT_LOGIC_FLAGS_EN
// Modports: master = producer/consumer side (bench, upstream logic),
//           slave  = the unit itself.
// -----------------------------------------------------------------------------
interface int_logic_if
    import int_logic_pkg::*;
#(
    parameter int DATA_W = 32
);

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic_op_e         op;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] dout;
    logic              busy;
`ifdef INT_LOGIC_FLAGS_EN
    logic              out_zero;
    logic              out_neg;
`endif

    modport master (
        output in_valid, a, b, op, out_ready,
`ifdef INT_LOGIC_FLAGS_EN
        input  out_zero, out_neg,
`endif
        input  in_ready, out_valid, dout, busy
    );

    modport slave (
        input  in_valid, a, b, op, out_ready,
`ifdef INT_LOGIC_FLAGS_EN
        output out_zero, out_neg,
`endif
        output in_ready, out_valid, dout, busy
    );

endinterface

// File: rtl/int_logic_stage.sv
// -----------------------------------------------------------------------------
// int_logic_stage
// One elastic valid/ready register slice.
//   clk, rst             : clock, synchronous active-high reset
//   ce                   : clock enable; 0 freezes the slice and drops up_ready
//   up_valid/up_data     : beat offered from upstream
//   up_ready             : slice will load this cycle
//   down_valid/down_data : registered beat presented downstream
//   down_ready           : downstream takes the beat this cycle
// The slice loads whenever it is empty or its beat leaves in the same cycle,
// so a full pipe of these slices still streams one beat per cycle.
// -----------------------------------------------------------------------------
module int_logic_stage #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ce,
    input  logic         up_valid,
    input  logic [W-1:0] up_data,
    output logic         up_ready,
    output logic         down_valid,
    output logic [W-1:0] down_data,
    input  logic         down_ready
);

    assign up_ready = ce && (!down_valid || down_ready);

    // NOTE: state registers use non-blocking (<=) so every slice samples the
    // pre-edge value of its neighbour; blocking here would shoot a beat
    // through several slices in one edge depending on evaluation order.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the data register is reset as well as the valid bit,
            // because the result bus must read zero after reset, not stale data.
            down_valid <= 1'b0;
            down_data  <= '0;
        end else if (up_ready) begin
            down_valid <= up_valid;
            // Loading a bubble keeps the old data so the bus does not toggle.
            if (up_valid) begin
                down_data <= up_data;
            end
        end
    end

endmodule

// File: rtl/int_logic_pipe.sv
// -----------------------------------------------------------------------------
// int_logic_pipe
// Pipelined integer logic/compare unit: OR, AND, SLT, SLTU, XOR, NOR, PASS_A,
// ZERO on DATA_W-bit operands, LATENCY elastic register stages deep.
//   clk  : clock, all logic on posedge
//   rst  : synchronous active-high reset, wins over ce
//   ce   : clock enable; 0 freezes every stage, in_ready=0, outputs held
//   bus  : int_logic_if.slave (operand handshake, result handshake, busy,
//          and out_zero/out_neg when INT_LOGIC_FLAGS_EN is defined)
// Optional feature macro: INT_LOGIC_FLAGS_EN -- zero/negative flags computed
// with the result and carried through the same stages as the data.
// -----------------------------------------------------------------------------
module int_logic_pipe
    import int_logic_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ce,
    int_logic_if.slave  bus
);

    if (LATENCY < 1 || LATENCY > LATENCY_MAX || DATA_W < 2) begin : g_bad_cfg
        $error("int_logic_pipe: need 1 <= LATENCY <= %0d and DATA_W >= 2", LATENCY_MAX);
    end

`ifdef INT_LOGIC_FLAGS_EN
    localparam int SW = DATA_W + 2;   // {neg, zero, result}
`else
    localparam int SW = DATA_W;
`endif

    // ---------------------------------------------------------------- decoder
    logic [DATA_W-1:0] result;
    logic              slt_bit;
    logic              sltu_bit;
    logic [SW-1:0]     stage_in;

    assign slt_bit  = $signed(bus.a) < $signed(bus.b);
    assign sltu_bit = bus.a < bus.b;

    always_comb begin
        // NOTE: default first so every path assigns result; an unassigned
        // path in always_comb would infer a latch.
        result = '0;
        case (bus.op)
            OP_OR:    result = bus.a | bus.b;
            OP_AND:   result = bus.a & bus.b;
            OP_SLT:   result = {{(DATA_W-1){1'b0}}, slt_bit};
            OP_SLTU:  result = {{(DATA_W-1){1'b0}}, sltu_bit};
            OP_XOR:   result = bus.a ^ bus.b;
            OP_NOR:   result = ~(bus.a | bus.b);
            OP_PASSA: result = bus.a;
            OP_ZERO:  result = '0;
            default:  result = '0;
        endcase
    end

`ifdef INT_LOGIC_FLAGS_EN
    assign stage_in = {result[DATA_W-1], (result == '0), result};
`else
    assign stage_in = result;
`endif

    // --------------------------------------------------------------- pipeline
    // Each generate block wires one slice to its neighbours by name; ready
    // flows backwards from out_ready, valid/data flow forwards.
    for (genvar k = 0; k < LATENCY; k++) begin : g_stage
        logic          up_valid;
        logic [SW-1:0] up_data;
        logic          ready;
        logic          valid;
        logic [SW-1:0] data;
        logic          down_ready;
        logic          busy_acc;   // OR of valids from stage 0 up to this one

        if (k == 0) begin : g_first
            assign up_valid = bus.in_valid;
            assign up_data  = stage_in;
            assign busy_acc = valid;
        end else begin : g_mid
            assign up_valid = g_stage[k-1].valid;
            assign up_data  = g_stage[k-1].data;
            assign busy_acc = valid | g_stage[k-1].busy_acc;
        end

        if (k == LATENCY - 1) begin : g_last
            assign down_ready = bus.out_ready;
        end else begin : g_next
            assign down_ready = g_stage[k+1].ready;
        end

        int_logic_stage #(
            .W (SW)
        ) u_stage (
            .clk        (clk),
            .rst        (rst),
            .ce         (ce),
            .up_valid   (up_valid),
            .up_data    (up_data),
            .up_ready   (ready),
            .down_valid (valid),
            .down_data  (data),
            .down_ready (down_ready)
        );
    end

    // ---------------------------------------------------------------- outputs
    // Stage 0 would happily load during reset; in_ready is masked so no beat
    // is reported as accepted at an edge that discards it.
    assign bus.in_ready  = !rst && g_stage[0].ready;
    assign bus.out_valid = g_stage[LATENCY-1].valid;
    assign bus.dout      = g_stage[LATENCY-1].data[DATA_W-1:0];
    assign bus.busy      = g_stage[LATENCY-1].busy_acc;

`ifdef INT_LOGIC_FLAGS_EN
    assign bus.out_zero  = g_stage[LATENCY-1].data[DATA_W];
    assign bus.out_neg   = g_stage[LATENCY-1].data[DATA_W+1];
`endif

endmodule

// File: tb/tb_int_logic_pipe.sv
// -----------------------------------------------------------------------------
// tb_int_logic_pipe
// Self-checking bench for int_logic_pipe (DATA_W=32, LATENCY=2).
// A queue of in-flight beats, each tagged with how many enabled edges it has
// seen, predicts out_valid, dout, busy and in_ready every cycle; directed
// cases pin literal results, backpressure, freeze and mid-stream reset.
// -----------------------------------------------------------------------------
module tb_int_logic_pipe;
    import int_logic_pkg::*;

    localparam int DATA_W  = 32;
    localparam int LATENCY = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ce  = 1'b1;

    always #5 clk = ~clk;

    int_logic_if #(.DATA_W(DATA_W)) bus ();

    int_logic_pipe #(
        .DATA_W  (DATA_W),
        .LATENCY (LATENCY)
    ) dut (
        .clk (clk),
        .rst (rst),
        .ce  (ce),
        .bus (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    // Reference semantics of each op, written straight from the op table.
    function automatic logic [DATA_W-1:0] model_op(input logic [DATA_W-1:0] a,
                                                   input logic [DATA_W-1:0] b,
                                                   input logic_op_e op);
        case (op)
            OP_OR:    return a | b;
            OP_AND:   return a & b;
            OP_SLT:   return ($signed(a) < $signed(b)) ? DATA_W'(1) : DATA_W'(0);
            OP_SLTU:  return (a < b) ? DATA_W'(1) : DATA_W'(0);
            OP_XOR:   return a ^ b;
            OP_NOR:   return ~(a | b);
            OP_PASSA: return a;
            default:  return '0;
        endcase
    endfunction

    // ------------------------------------------------------------- model
    typedef struct {
        logic [DATA_W-1:0] res;
        int                age;   // enabled edges seen since acceptance
    } beat_t;

    beat_t q[$];

    always @(negedge clk) begin
        logic exp_valid;
        logic exp_ready;
        if (rst) begin
            check("in_ready_in_reset", 64'(bus.in_ready), 64'(0));
            q.delete();
        end else begin
            exp_valid = (q.size() > 0) && (q[0].age >= LATENCY - 1);
            exp_ready = ce && ((q.size() < LATENCY) || bus.out_ready);
            check("out_valid", 64'(bus.out_valid), 64'(exp_valid));
            check("busy", 64'(bus.busy), 64'(q.size() > 0));
            check("in_ready", 64'(bus.in_ready), 64'(exp_ready));
            if (exp_valid) begin
                check("dout", 64'(bus.dout), 64'(q[0].res));
`ifdef INT_LOGIC_FLAGS_EN
                check("out_zero", 64'(bus.out_zero), 64'(q[0].res == '0));
                check("out_neg", 64'(bus.out_neg), 64'(q[0].res[DATA_W-1]));
`endif
            end
            if (ce && exp_valid && bus.out_ready) void'(q.pop_front());
            if (ce) begin
                for (int i = 0; i < q.size(); i++) q[i].age = q[i].age + 1;
            end
            if (bus.in_valid && exp_ready) begin
                beat_t nb;
                nb.res = model_op(bus.a, bus.b, bus.op);
                nb.age = 0;
                q.push_back(nb);
            end
        end
    end

    // ------------------------------------------------------------- helpers
    function automatic logic [DATA_W-1:0] rand_operand();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return '1;
            2:       return DATA_W'(1);
            3:       return {1'b1, {(DATA_W-1){1'b0}}};
            4:       return {1'b0, {(DATA_W-1){1'b1}}};
            default: return DATA_W'($urandom);
        endcase
    endfunction

    task automatic drive_random_beat();
        logic [2:0] r;
        r = 3'($urandom_range(0, 7));
        bus.a  = rand_operand();
        bus.b  = rand_operand();
        bus.op = logic_op_e'(r);
    endtask

    // Offer one beat, then check the literal result LATENCY cycles on.
    task automatic send_directed(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                                 input logic_op_e op, input logic [DATA_W-1:0] exp,
                                 input string name);
        bus.a = a; bus.b = b; bus.op = op; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        for (int i = 1; i < LATENCY; i++) begin
            @(posedge clk); #1;
        end
        check({name, "_valid"}, 64'(bus.out_valid), 64'(1));
        check(name, 64'(bus.dout), 64'(exp));
    endtask

    task automatic wait_empty(input string name);
        int n = 0;
        while (bus.busy !== 1'b0 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check({name, "_drained"}, 64'(bus.busy), 64'(0));
        check({name, "_model_empty"}, 64'(q.size()), 64'(0));
    endtask

    // ------------------------------------------------------------- stimulus
    initial begin
        int acc;
        logic              held_valid;
        logic [DATA_W-1:0] held_dout;

        bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.op = OP_OR;
        bus.out_ready = 1'b1;
        rst = 1'b1; ce = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(bus.out_valid), 64'(0));
        check("rst_dout", 64'(bus.dout), 64'(0));
        check("rst_busy", 64'(bus.busy), 64'(0));
        check("rst_in_ready", 64'(bus.in_ready), 64'(0));
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", 64'(bus.in_ready), 64'(1));

        // Op table with the reference operands.
        send_directed(32'hF0F0_0000, 32'h0FF0_FFFF, OP_OR,    32'hFFF0_FFFF, "op_or");
        send_directed(32'hF0F0_0000, 32'h0FF0_FFFF, OP_AND,   32'h00F0_0000, "op_and");
        send_directed(32'hF0F0_0000, 32'h0FF0_FFFF, OP_SLT,   32'h0000_0001, "op_slt");
        send_directed(32'hF0F0_0000, 32'h0FF0_FFFF, OP_SLTU,  32'h0000_0000, "op_sltu");
        send_directed(32'hF0F0_0000, 32'h0FF0_FFFF, OP_XOR,   32'hFF00_FFFF, "op_xor");
        send_directed(32'hF0F0_0000, 32'h0FF0_FFFF, OP_NOR,   32'h000F_0000, "op_nor");
        send_directed(32'hF0F0_0000, 32'h0FF0_FFFF, OP_PASSA, 32'hF0F0_0000, "op_passa");
        send_directed(32'hF0F0_0000, 32'h0FF0_FFFF, OP_ZERO,  32'h0000_0000, "op_zero");
        // Compare edges: equal operands, and the signed/unsigned split at the MSB.
        send_directed(32'h8000_0000, 32'h8000_0000, OP_SLT,   32'h0000_0000, "slt_equal");
        send_directed(32'h7FFF_FFFF, 32'h8000_0000, OP_SLTU,  32'h0000_0001, "sltu_msb");
        send_directed(32'h7FFF_FFFF, 32'h8000_0000, OP_SLT,   32'h0000_0000, "slt_msb");
`ifdef INT_LOGIC_FLAGS_EN
        send_directed(32'h8000_0000, 32'h0000_0000, OP_OR,    32'h8000_0000, "flag_or");
        check("flag_or_neg", 64'(bus.out_neg), 64'(1));
        check("flag_or_zero", 64'(bus.out_zero), 64'(0));
        send_directed(32'h8000_0000, 32'h0000_0000, OP_AND,   32'h0000_0000, "flag_and");
        check("flag_and_neg", 64'(bus.out_neg), 64'(0));
        check("flag_and_zero", 64'(bus.out_zero), 64'(1));
`endif
        wait_empty("directed");

        // Streaming: 16 back-to-back beats with the sink always ready.
        for (int i = 0; i < 16; i++) begin
            drive_random_beat();
            bus.in_valid = 1'b1;
            check("stream_in_ready", 64'(bus.in_ready), 64'(1));
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        wait_empty("stream");

        // Backpressure: sink stalled for 5 cycles while the source keeps offering.
        bus.out_ready = 1'b0;
        acc = 0;
        for (int i = 0; i < 5; i++) begin
            drive_random_beat();
            bus.in_valid = 1'b1;
            @(negedge clk);
            if (bus.in_ready) acc++;
            @(posedge clk); #1;
        end
        check("bp_absorbed", 64'(acc), 64'(LATENCY));
        check("bp_in_ready", 64'(bus.in_ready), 64'(0));
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        wait_empty("bp");

        // Clock-enable freeze in the middle of mixed traffic.
        for (int i = 0; i < 4; i++) begin
            drive_random_beat();
            bus.in_valid = 1'b1;
            bus.out_ready = (i != 2);
            @(posedge clk); #1;
        end
        ce = 1'b0;
        bus.out_ready = 1'b1;
        held_valid = bus.out_valid;
        held_dout  = bus.dout;
        for (int i = 0; i < 3; i++) begin
            drive_random_beat();
            @(posedge clk); #1;
            check("ce_hold_valid", 64'(bus.out_valid), 64'(held_valid));
            check("ce_hold_dout", 64'(bus.dout), 64'(held_dout));
            check("ce_in_ready", 64'(bus.in_ready), 64'(0));
        end
        ce = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive_random_beat();
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        wait_empty("ce");

        // Reset with two beats in flight and the sink stalled.
        bus.out_ready = 1'b0;
        bus.a = 32'hDEAD_BEEF; bus.b = '0; bus.op = OP_PASSA; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.a = 32'h1234_5678;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        check("midrst_out_valid", 64'(bus.out_valid), 64'(0));
        check("midrst_dout", 64'(bus.dout), 64'(0));
        check("midrst_busy", 64'(bus.busy), 64'(0));
        check("midrst_in_ready", 64'(bus.in_ready), 64'(0));
        rst = 1'b0;
        bus.out_ready = 1'b1;
        #1;
        check("midrst_in_ready_after", 64'(bus.in_ready), 64'(1));
        repeat (LATENCY + 3) @(posedge clk);
        #1;
        wait_empty("midrst");

        // Randomized traffic: valid, sink ready, ce and occasional reset.
        for (int i = 0; i < 3000; i++) begin
            drive_random_beat();
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            ce            = ($urandom_range(0, 7) != 0);
            rst           = ($urandom_range(0, 199) == 0);
            @(posedge clk); #1;
        end
        rst = 1'b0; ce = 1'b1; bus.out_ready = 1'b1; bus.in_valid = 1'b0;
        wait_empty("random");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
